// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared memory bus.
// A grant latches the request, runs one bus access with timeout, then pulses done.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req0,
   input  logic        req1,
   input  logic        rw0,
   input  logic        rw1,
   input  logic [31:0] addr0,
   input  logic [31:0] addr1,
   input  logic [31:0] wdata0,
   input  logic [31:0] wdata1,
   output logic        done0,
   output logic        done1,
   output logic        err0,
   output logic        err1,
   output logic [31:0] rdata,
   output logic [31:0] addressBus,
   inout  logic [31:0] dataBus,
   output logic        memRWPin,
   output logic        memValid,
   input  logic        memOpDone
);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic        last_q, last_d;
   logic        gnt_q, gnt_d;
   logic        rw_q, rw_d;
   logic        err_q, err_d;
   logic [15:0] cnt_q, cnt_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         rw_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         rw_q    <= rw_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      rw_d    = rw_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               // On a tie the port not served last wins.
               gnt_d   = (req0 && req1) ? ~last_q : req1;
               last_d  = gnt_d;
               rw_d    = gnt_d ? rw1 : rw0;
               addr_d  = gnt_d ? addr1 : addr0;
               wdata_d = gnt_d ? wdata1 : wdata0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            if (memOpDone) begin
               if (!rw_q) rdata_d = dataBus;
               err_d   = 1'b0;
               state_d = RESP;
            end else if (cnt_q == CNT_LAST) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = RESP;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign memValid   = (state_q == ACCESS);
   assign memRWPin   = memValid & rw_q;
   assign addressBus = addr_q;
   assign dataBus    = (memValid && rw_q) ? wdata_q : 'z;
   assign rdata      = rdata_q;
   assign done0      = (state_q == RESP) & ~gnt_q;
   assign done1      = (state_q == RESP) & gnt_q;
   assign err0       = done0 & err_q;
   assign err1       = done1 & err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model
// that tracks the owner, grant time and response phase of each access.
module tb_mem_port_arbiter;

   localparam int unsigned TO    = 8;
   localparam logic [31:0] PROBE = 32'hA5C3_0F69;

   logic        clk = 1'b0;
   logic        reset;
   logic        req0, req1, rw0, rw1;
   logic [31:0] addr0, addr1, wdata0, wdata1;
   logic        done0, done1, err0, err1;
   logic [31:0] rdata, addressBus;
   wire  [31:0] dataBus;
   logic        memRWPin, memValid, memOpDone;
   logic [31:0] rd_val;

   always #5 clk = ~clk;

   // Memory model: returns read data during a read access, otherwise
   // holds a probe pattern on the bus so a stray DUT driver is visible.
   assign dataBus = (memValid && memRWPin) ? 'z : (memValid ? rd_val : PROBE);

   mem_port_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .req1(req1), .rw0(rw0), .rw1(rw1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .done0(done0), .done1(done1), .err0(err0), .err1(err1),
      .rdata(rdata), .addressBus(addressBus), .dataBus(dataBus),
      .memRWPin(memRWPin), .memValid(memValid), .memOpDone(memOpDone)
   );

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   int          cyc   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model state
   int          owner  = -1;
   bit          resp   = 1'b0;
   int          last_p = 1;
   int          t_grant = 0;
   bit          m_rw   = 1'b0;
   bit          m_err  = 1'b0;
   logic [31:0] m_addr = '0, m_wdata = '0, m_rdata = '0;

   initial begin
      int pct [5] = '{35, 100, 0, 15, 60};
      logic rq [2];
      logic ev;
      logic [31:0] exp_bus;
      int g;
      rq[0] = 1'b0; rq[1] = 1'b0;
      reset = 1'b1; req0 = 1'b0; req1 = 1'b0; rw0 = 1'b0; rw1 = 1'b0;
      addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
      memOpDone = 1'b0; rd_val = '0;

      for (int s = 0; s < 5; s++) begin
         for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            reset = (cyc < 2) || ($urandom_range(0, 79) == 0);
            for (int p = 0; p < 2; p++) begin
               if (resp && owner == p)
                  rq[p] = ($urandom_range(0, 9) == 0);
               else if (!rq[p])
                  rq[p] = ($urandom_range(0, 99) < 30);
            end
            req0 = rq[0]; req1 = rq[1];
            rw0 = 1'($urandom); rw1 = 1'($urandom);
            addr0 = $urandom; addr1 = $urandom;
            wdata0 = $urandom; wdata1 = $urandom;
            memOpDone = ($urandom_range(0, 99) < pct[s]);
            rd_val = $urandom;
            #1;
            if (cyc > 0) begin
               ev = (owner >= 0) && !resp;
               exp_bus = (ev && m_rw) ? m_wdata : (ev ? rd_val : PROBE);
               check("memValid", 32'(memValid), 32'(ev));
               check("memRWPin", 32'(memRWPin), 32'(ev && m_rw));
               check("addressBus", addressBus, m_addr);
               check("dataBus", dataBus, exp_bus);
               check("done0", 32'(done0), 32'(resp && owner == 0));
               check("done1", 32'(done1), 32'(resp && owner == 1));
               check("err0", 32'(err0), 32'(resp && owner == 0 && m_err));
               check("err1", 32'(err1), 32'(resp && owner == 1 && m_err));
               check("rdata", rdata, m_rdata);
            end
            @(posedge clk);
            if (reset) begin
               owner = -1; resp = 1'b0; last_p = 1;
               m_rw = 1'b0; m_err = 1'b0;
               m_addr = '0; m_wdata = '0; m_rdata = '0;
            end else if (owner < 0) begin
               if (req0 || req1) begin
                  g = (req0 && req1) ? 1 - last_p : (req0 ? 0 : 1);
                  owner = g; last_p = g; t_grant = cyc; m_err = 1'b0;
                  m_rw    = (g == 0) ? rw0 : rw1;
                  m_addr  = (g == 0) ? addr0 : addr1;
                  m_wdata = (g == 0) ? wdata0 : wdata1;
               end
            end else if (!resp) begin
               if (memOpDone) begin
                  if (!m_rw) m_rdata = rd_val;
                  m_err = 1'b0; resp = 1'b1;
               end else if (cyc - t_grant == int'(TO)) begin
                  m_rdata = '0; m_err = 1'b1; resp = 1'b1;
               end
            end else begin
               owner = -1; resp = 1'b0;
            end
            cyc++;
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
